voter_console: RTL and testbench
================================

VOTER_CONSOLE -- requirements
Module: voter_console

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: cycles allowed in WAIT_READY or WAIT_RESP before timeout.
REQ-002 Parameter MAX_RETRIES, default 2: resubmissions after a WAIT_RESP timeout.
REQ-003 Parameter AUTH_GAP, default 2: idle cycles between the authenticate_voter pulse and the submit_vote pulse.
REQ-004 Parameter NUM_CANDIDATES, default 4: candidate IDs at or above this value are invalid.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  single system clock, rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 ballot_valid  input  1  upstream ballot offered.
REQ-009 ballot_ready  output  1  console accepts a ballot.
REQ-010 ballot_voter_id  input  8  voter ID of the offered ballot.
REQ-011 ballot_candidate  input  4  candidate of the offered ballot.
REQ-012 voter_id_out  output  8  voter ID driven to the voting controller.
REQ-013 candidate_out  output  4  candidate driven to the voting controller.
REQ-014 authenticate_voter  output  1  one-cycle authenticate pulse.
REQ-015 submit_vote  output  1  one-cycle submit pulse.
REQ-016 system_ready  input  1  controller ready.
REQ-017 vote_accepted  input  1  controller accept.
REQ-018 vote_rejected  input  1  controller reject.
REQ-019 error_code  input  8  controller error code, sampled on reject.
REQ-020 done  output  1  one-cycle ballot-complete pulse.
REQ-021 done_status  output  2  outcome: 0 ACCEPT, 1 REJECT, 2 TIMEOUT, 3 LOCAL_REJECT.
REQ-022 done_error  output  8  captured error_code; 0 unless the outcome is REJECT.
REQ-023 accepted_count / rejected_count  output  16 each  saturating tallies.
REQ-024 busy  output  1  high in every state except IDLE.

Function
REQ-025 FSM states: IDLE, WAIT_READY, AUTH, GAP, SUBMIT, WAIT_RESP, REPORT.
REQ-026 IDLE: ballot_ready=1; on ballot_valid&&ballot_ready, capture the ID and candidate into voter_id_out/candidate_out, clear the retry count, and go to WAIT_READY, or go to REPORT with LOCAL_REJECT if candidate>=NUM_CANDIDATES.
REQ-027 ballot_ready is 0 in all states other than IDLE; there is no buffering beyond one ballot.
REQ-028 WAIT_READY: when system_ready=1, go to AUTH next cycle; the timer is cleared on entry; if the timer reaches TIMEOUT_CYCLES, go to REPORT with TIMEOUT.
REQ-029 AUTH: authenticate_voter=1 for exactly one cycle, then GAP.
REQ-030 GAP: hold for exactly AUTH_GAP cycles; AUTH_GAP=0 means SUBMIT directly follows AUTH.
REQ-031 SUBMIT: submit_vote=1 for exactly one cycle, then WAIT_RESP with the timer cleared.
REQ-032 WAIT_RESP: on vote_accepted, go to REPORT with ACCEPT.
REQ-033 WAIT_RESP: on vote_rejected, go to REPORT with REJECT and latch error_code.
REQ-034 WAIT_RESP: if accept and reject arrive in the same cycle, REJECT wins.
REQ-035 WAIT_RESP timeout: if retries<MAX_RETRIES, increment the retry count and return to WAIT_READY; otherwise go to REPORT with TIMEOUT.
REQ-036 Accept/reject inputs outside WAIT_RESP are ignored.
REQ-037 REPORT: done=1 for one cycle with done_status/done_error valid; ACCEPT increments accepted_count; REJECT and LOCAL_REJECT increment rejected_count; both counters hold at 16'hFFFF; then IDLE.
REQ-038 voter_id_out/candidate_out hold the captured values until the next capture.

Reset
REQ-039 Asserting reset_n low at any time forces IDLE immediately and clears all outputs, counters and the timer to 0, except ballot_ready, which is 1 after reset.
REQ-040 A ballot in flight at reset is dropped with no done pulse.

Configuration
REQ-041 With CONSOLE_DUP_GUARD_EN defined, a 256-bit seen-ID bitmap is kept; a voter ID is marked seen on ACCEPT.
REQ-042 With CONSOLE_DUP_GUARD_EN defined, a captured ballot whose ID is already marked goes IDLE->REPORT with LOCAL_REJECT and no controller pulses.
REQ-043 The bitmap is cleared only by reset.
REQ-044 Without CONSOLE_DUP_GUARD_EN, no bitmap exists and duplicate IDs are forwarded to the controller.

Structure
REQ-045 Package voter_console_pkg holds the FSM state enum, the 2-bit status code constants and the parameter defaults.
REQ-046 Sub-module console_timeout_timer: clear/enable inputs, an expired output at TIMEOUT_CYCLES; it is shared by WAIT_READY and WAIT_RESP.

Verification
REQ-047 Ballot ID 8'h11, candidate 2, system_ready=1, accept 3 cycles after submit -> authenticate at cycle t, submit at t+3, done with ACCEPT, accepted_count=1.
REQ-048 Candidate 5 (NUM_CANDIDATES=4) -> no authenticate/submit, done with LOCAL_REJECT, rejected_count=1.
REQ-049 Reject with error_code 8'h2A asserted together with accept -> done with REJECT, done_error=8'h2A.
REQ-050 No response, TIMEOUT_CYCLES=8, MAX_RETRIES=2 -> exactly 3 submit pulses, then done with TIMEOUT.
REQ-051 reset_n low during WAIT_RESP -> immediate IDLE, no done, counters 0; with CONSOLE_DUP_GUARD_EN, a second accepted-then-resubmitted ID 8'h11 -> LOCAL_REJECT.
REQ-052 accepted_count preloaded by 65535 accepts, one further accept -> count stays 16'hFFFF.

Source files
------------

// File: rtl/voter_console_pkg.sv
// Shared types and defaults for the voter console: FSM states, done_status
// encodings and parameter defaults.
package voter_console_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_READY,
    AUTH,
    GAP,
    SUBMIT,
    WAIT_RESP,
    REPORT
  } state_t;

  localparam logic [1:0] ST_ACCEPT       = 2'd0;
  localparam logic [1:0] ST_REJECT       = 2'd1;
  localparam logic [1:0] ST_TIMEOUT      = 2'd2;
  localparam logic [1:0] ST_LOCAL_REJECT = 2'd3;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
  localparam int unsigned DEF_MAX_RETRIES    = 2;
  localparam int unsigned DEF_AUTH_GAP       = 2;
  localparam int unsigned DEF_NUM_CANDIDATES = 4;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/voter_console_if.sv
// Upstream ballot handshake: valid/ready with voter ID and candidate.
interface voter_console_if;
  logic       ballot_valid;
  logic       ballot_ready;
  logic [7:0] ballot_voter_id;
  logic [3:0] ballot_candidate;

  modport master (output ballot_valid, ballot_voter_id, ballot_candidate,
                  input  ballot_ready);
  modport slave  (input  ballot_valid, ballot_voter_id, ballot_candidate,
                  output ballot_ready);
endinterface

// File: rtl/voter_console_timer.sv
// Timeout timer shared by WAIT_READY and WAIT_RESP; expired holds once the
// count reaches TIMEOUT_CYCLES until the next clear.
module console_timeout_timer
  import voter_console_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 2);

  logic [W-1:0] count;

  assign expired = (count == W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               count <= '0;
    else if (clear)             count <= '0;
    else if (enable && !expired) count <= count + 1'b1;
  end
endmodule

// File: rtl/voter_console.sv
// Voter console: takes one ballot at a time, drives the authenticate/submit
// sequence to the controller and reports the outcome. Optional duplicate-ID
// guard enabled with `define CONSOLE_DUP_GUARD_EN.
module voter_console
  import voter_console_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int unsigned AUTH_GAP       = DEF_AUTH_GAP,
  parameter int unsigned NUM_CANDIDATES = DEF_NUM_CANDIDATES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  voter_console_if.slave        ballot,
  output logic [7:0]            voter_id_out,
  output logic [3:0]            candidate_out,
  output logic                  authenticate_voter,
  output logic                  submit_vote,
  input  logic                  system_ready,
  input  logic                  vote_accepted,
  input  logic                  vote_rejected,
  input  logic [7:0]            error_code,
  output logic                  done,
  output logic [1:0]            done_status,
  output logic [7:0]            done_error,
  output logic [15:0]           accepted_count,
  output logic [15:0]           rejected_count,
  output logic                  busy
);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 2);
  localparam int unsigned GW = $clog2(AUTH_GAP + 2);

  state_t        state, state_next;
  logic [RW-1:0] retry_cnt;
  logic [GW-1:0] gap_cnt;
  logic [15:0]   acc_cnt, rej_cnt;
  logic          timer_expired;
  logic          dup_hit;
  logic          rep_load, retry_inc;
  logic [1:0]    rep_status;
  logic [7:0]    rep_error;

  assign ballot.ballot_ready = (state == IDLE);
  assign busy                = (state != IDLE);
  assign authenticate_voter  = (state == AUTH);
  assign submit_vote         = (state == SUBMIT);
  assign done                = (state == REPORT);
  assign accepted_count      = acc_cnt;
  assign rejected_count      = rej_cnt;

  // Every state change restarts the timer, so both timed states begin at zero.
  console_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_next != state),
    .enable  ((state == WAIT_READY) || (state == WAIT_RESP)),
    .expired (timer_expired)
  );

`ifdef CONSOLE_DUP_GUARD_EN
  logic [255:0] seen;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      seen <= '0;
    else if (state == REPORT && done_status == ST_ACCEPT)
      seen[voter_id_out] <= 1'b1;
  end
  assign dup_hit = seen[ballot.ballot_voter_id];
`else
  assign dup_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    rep_load   = 1'b0;
    rep_status = ST_ACCEPT;
    rep_error  = '0;
    retry_inc  = 1'b0;
    unique case (state)
      IDLE: if (ballot.ballot_valid) begin
        if (32'(ballot.ballot_candidate) >= NUM_CANDIDATES || dup_hit) begin
          state_next = REPORT;
          rep_load   = 1'b1;
          rep_status = ST_LOCAL_REJECT;
        end else begin
          state_next = WAIT_READY;
        end
      end
      WAIT_READY: begin
        if (system_ready) state_next = AUTH;
        else if (timer_expired) begin
          state_next = REPORT;
          rep_load   = 1'b1;
          rep_status = ST_TIMEOUT;
        end
      end
      AUTH:   state_next = (AUTH_GAP == 0) ? SUBMIT : GAP;
      GAP:    if (32'(gap_cnt) == AUTH_GAP - 1) state_next = SUBMIT;
      SUBMIT: state_next = WAIT_RESP;
      WAIT_RESP: begin
        if (vote_rejected) begin
          state_next = REPORT;
          rep_load   = 1'b1;
          rep_status = ST_REJECT;
          rep_error  = error_code;
        end else if (vote_accepted) begin
          state_next = REPORT;
          rep_load   = 1'b1;
          rep_status = ST_ACCEPT;
        end else if (timer_expired) begin
          if (32'(retry_cnt) < MAX_RETRIES) begin
            state_next = WAIT_READY;
            retry_inc  = 1'b1;
          end else begin
            state_next = REPORT;
            rep_load   = 1'b1;
            rep_status = ST_TIMEOUT;
          end
        end
      end
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      voter_id_out  <= '0;
      candidate_out <= '0;
      retry_cnt     <= '0;
      gap_cnt       <= '0;
      done_status   <= '0;
      done_error    <= '0;
      acc_cnt       <= '0;
      rej_cnt       <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && ballot.ballot_valid) begin
        voter_id_out  <= ballot.ballot_voter_id;
        candidate_out <= ballot.ballot_candidate;
        retry_cnt     <= '0;
      end else if (retry_inc) begin
        retry_cnt <= retry_cnt + 1'b1;
      end
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (rep_load) begin
        done_status <= rep_status;
        done_error  <= rep_error;
      end
      if (state == REPORT) begin
        if (done_status == ST_ACCEPT && acc_cnt != CNT_MAX)
          acc_cnt <= acc_cnt + 16'd1;
        if ((done_status == ST_REJECT || done_status == ST_LOCAL_REJECT) && rej_cnt != CNT_MAX)
          rej_cnt <= rej_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_voter_console.sv
// Directed bench for voter_console; expected done outcomes are queued when a
// ballot is offered and compared when the console pulses done.
module tb_voter_console;
  import voter_console_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  voter_id_out;
  logic [3:0]  candidate_out;
  logic        authenticate_voter, submit_vote;
  logic        system_ready = 1'b0, vote_accepted = 1'b0, vote_rejected = 1'b0;
  logic [7:0]  error_code = 8'h00;
  logic        done, busy;
  logic [1:0]  done_status;
  logic [7:0]  done_error;
  logic [15:0] accepted_count, rejected_count;

  voter_console_if bif ();

  voter_console #(
    .TIMEOUT_CYCLES (8),
    .MAX_RETRIES    (2),
    .AUTH_GAP       (2),
    .NUM_CANDIDATES (4)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .ballot             (bif),
    .voter_id_out       (voter_id_out),
    .candidate_out      (candidate_out),
    .authenticate_voter (authenticate_voter),
    .submit_vote        (submit_vote),
    .system_ready       (system_ready),
    .vote_accepted      (vote_accepted),
    .vote_rejected      (vote_rejected),
    .error_code         (error_code),
    .done               (done),
    .done_status        (done_status),
    .done_error         (done_error),
    .accepted_count     (accepted_count),
    .rejected_count     (rejected_count),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_total = 0;
  int n_pass  = 0;
  int cyc = 0;
  int auth_n = 0, sub_n = 0, t_auth = 0, t_sub = 0;
  int a0, s0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (authenticate_voter) begin auth_n++; t_auth = cyc; end
    if (submit_vote)        begin sub_n++;  t_sub  = cyc; end
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
      else begin
        e = sb.pop_front();
        chk("done_status", 32'(done_status), 32'(e.st));
        chk("done_error",  32'(done_error),  32'(e.err));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_done(input logic [1:0] st, input logic [7:0] err);
    sb.push_back({st, err});
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 300) begin step(); k++; end
    if (busy !== 1'b0) chk("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic offer(input logic [7:0] id, input logic [3:0] cand);
    wait_idle();
    bif.ballot_valid     = 1'b1;
    bif.ballot_voter_id  = id;
    bif.ballot_candidate = cand;
    step();
    bif.ballot_valid = 1'b0;
  endtask

  task automatic wait_submit(input int n0);
    int k = 0;
    while (sub_n <= n0 && k < 100) begin step(); k++; end
    if (sub_n <= n0) chk("submit_wait", 32'(sub_n), 32'(n0 + 1));
  endtask

  task automatic wait_done();
    int k = 0;
    while (sb.size() != 0 && k < 400) begin step(); k++; end
    if (sb.size() != 0) begin
      chk("done_wait", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    step();
  endtask

  task automatic accept_ballot(input logic [7:0] id, input logic [3:0] cand);
    int s;
    s = sub_n;
    expect_done(ST_ACCEPT, 8'h00);
    offer(id, cand);
    wait_submit(s);
    step();
    vote_accepted = 1'b1;
    step();
    vote_accepted = 1'b0;
    wait_done();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.ballot_valid     = 1'b0;
    bif.ballot_voter_id  = 8'h00;
    bif.ballot_candidate = 4'h0;
    step(); step(); step();
    chk("rst_ballot_ready", 32'(bif.ballot_ready), 32'd1);
    chk("rst_busy",         32'(busy), 32'd0);
    chk("rst_done",         32'(done), 32'd0);
    chk("rst_acc",          32'(accepted_count), 32'd0);
    chk("rst_rej",          32'(rejected_count), 32'd0);
    chk("rst_voter_id",     32'(voter_id_out), 32'd0);
    reset_n = 1'b1;
    step();

    // accept three cycles after submit, authenticate-to-submit spacing
    system_ready = 1'b1;
    a0 = auth_n; s0 = sub_n;
    expect_done(ST_ACCEPT, 8'h00);
    offer(8'h11, 4'd2);
    wait_submit(s0);
    chk("busy_in_flight",  32'(busy), 32'd1);
    chk("ready_in_flight", 32'(bif.ballot_ready), 32'd0);
    step(); step();
    vote_accepted = 1'b1;
    step();
    vote_accepted = 1'b0;
    wait_done();
    chk("t1_auth_pulses", 32'(auth_n - a0), 32'd1);
    chk("t1_sub_pulses",  32'(sub_n - s0), 32'd1);
    chk("t1_auth_to_sub", 32'(t_sub - t_auth), 32'd3);
    chk("t1_acc_count",   32'(accepted_count), 32'd1);
    chk("t1_voter_id",    32'(voter_id_out), 32'h11);
    chk("t1_candidate",   32'(candidate_out), 32'd2);

    // out-of-range candidate
    a0 = auth_n; s0 = sub_n;
    expect_done(ST_LOCAL_REJECT, 8'h00);
    offer(8'h22, 4'd5);
    wait_done();
    chk("t2_no_auth",   32'(auth_n), 32'(a0));
    chk("t2_no_submit", 32'(sub_n), 32'(s0));
    chk("t2_rej_count", 32'(rejected_count), 32'd1);
    chk("t2_acc_count", 32'(accepted_count), 32'd1);

    // accept and reject together: reject wins with its error code
    s0 = sub_n;
    expect_done(ST_REJECT, 8'h2A);
    offer(8'h33, 4'd1);
    wait_submit(s0);
    step();
    error_code = 8'h2A; vote_accepted = 1'b1; vote_rejected = 1'b1;
    step();
    error_code = 8'h00; vote_accepted = 1'b0; vote_rejected = 1'b0;
    wait_done();
    chk("t3_rej_count", 32'(rejected_count), 32'd2);
    chk("t3_acc_count", 32'(accepted_count), 32'd1);

    // controller never ready; a stray accept outside WAIT_RESP is ignored
    system_ready = 1'b0;
    vote_accepted = 1'b1;
    a0 = auth_n;
    expect_done(ST_TIMEOUT, 8'h00);
    offer(8'h44, 4'd0);
    wait_done();
    vote_accepted = 1'b0;
    chk("t4_no_auth",   32'(auth_n), 32'(a0));
    chk("t4_acc_count", 32'(accepted_count), 32'd1);

    // no response: initial submit plus two retries, then timeout
    system_ready = 1'b1;
    a0 = auth_n; s0 = sub_n;
    expect_done(ST_TIMEOUT, 8'h00);
    offer(8'h55, 4'd3);
    wait_done();
    chk("t5_sub_pulses",  32'(sub_n - s0), 32'd3);
    chk("t5_auth_pulses", 32'(auth_n - a0), 32'd3);
    chk("t5_rej_count",   32'(rejected_count), 32'd2);

    // reset while waiting for a response drops the ballot
    s0 = sub_n;
    offer(8'h66, 4'd1);
    wait_submit(s0);
    step();
    reset_n = 1'b0;
    #1;
    chk("t6_busy",     32'(busy), 32'd0);
    chk("t6_ready",    32'(bif.ballot_ready), 32'd1);
    chk("t6_done",     32'(done), 32'd0);
    chk("t6_acc",      32'(accepted_count), 32'd0);
    chk("t6_rej",      32'(rejected_count), 32'd0);
    chk("t6_voter_id", 32'(voter_id_out), 32'd0);
    step(); step();
    reset_n = 1'b1;
    step(); step();
    chk("t6_acc_after", 32'(accepted_count), 32'd0);

    // resubmitting an already accepted voter ID
    accept_ballot(8'h11, 4'd2);
    chk("t7_acc_count", 32'(accepted_count), 32'd1);
    a0 = auth_n;
`ifdef CONSOLE_DUP_GUARD_EN
    expect_done(ST_LOCAL_REJECT, 8'h00);
    offer(8'h11, 4'd3);
    wait_done();
    chk("t7_dup_no_auth", 32'(auth_n), 32'(a0));
    chk("t7_dup_rej",     32'(rejected_count), 32'd1);
`else
    accept_ballot(8'h11, 4'd3);
    chk("t7_dup_forwarded", 32'(auth_n - a0), 32'd1);
    chk("t7_dup_acc",       32'(accepted_count), 32'd2);
`endif

    // accepted_count saturation from a preloaded value
    force dut.acc_cnt = 16'hFFFE;
    step();
    release dut.acc_cnt;
    step();
    chk("t8_preload", 32'(accepted_count), 32'h0000FFFE);
    accept_ballot(8'h77, 4'd0);
    chk("t8_reach_max", 32'(accepted_count), 32'h0000FFFF);
    accept_ballot(8'h78, 4'd1);
    chk("t8_saturate", 32'(accepted_count), 32'h0000FFFF);

    chk("queue_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
